// File: rtl/m_div_controller.sv
// Sequencing FSM for a 32-iteration restoring divider: drives the
// datapath selects and forms the signed/unsigned final result.
`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH   2
`define MUX_R_KEEP     2'd0
`define MUX_R_A        2'd1
`define MUX_R_A_NEG    2'd2
`define MUX_R_SUB_KEEP 2'd3
`endif
`ifndef MUX_D_LENGTH
`define MUX_D_LENGTH   2
`define MUX_D_KEEP     2'd0
`define MUX_D_B        2'd1
`define MUX_D_B_NEG    2'd2
`define MUX_D_SHR      2'd3
`endif
`ifndef MUX_Z_LENGTH
`define MUX_Z_LENGTH   2
`define MUX_Z_KEEP     2'd0
`define MUX_Z_ZERO     2'd1
`define MUX_Z_SHL_ADD  2'd2
`endif

module m_div_controller #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [31:0]              rs1,
    input  logic [31:0]              rs2,
    input  logic [31:0]              R,
    input  logic [31:0]              Z,
    output logic [`MUX_R_LENGTH-1:0] mux_R,
    output logic [`MUX_D_LENGTH-1:0] mux_D,
    output logic [`MUX_Z_LENGTH-1:0] mux_Z,
    output logic                     busy,
    output logic                     valid,
    output logic [31:0]              result
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        is_rem, qneg, rneg, dz, ovf;
    logic        sgn, dz_in, ovf_in, accept;
    logic [31:0] quo, rem, res_nx;

    assign sgn    = ~op[0];
    assign dz_in  = (rs2 == 32'd0);
    assign ovf_in = sgn & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    // resetn gating keeps the selects at KEEP while reset is held
    assign accept = (state == IDLE) & start & resetn;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mux_R    = `MUX_R_KEEP;
        mux_D    = `MUX_D_KEEP;
        mux_Z    = `MUX_Z_KEEP;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = 5'd0;
                    mux_R  = (sgn & rs1[31]) ? `MUX_R_A_NEG : `MUX_R_A;
                    mux_D  = (sgn & rs2[31]) ? `MUX_D_B_NEG : `MUX_D_B;
                    mux_Z  = `MUX_Z_ZERO;
                    if (FAST_SPECIAL && (dz_in || ovf_in))
                        state_nx = DONE;
                    else
                        state_nx = ITER;
                end
            end
            ITER: begin
                mux_R  = `MUX_R_SUB_KEEP;
                mux_D  = `MUX_D_SHR;
                mux_Z  = `MUX_Z_SHL_ADD;
                cnt_nx = cnt + 5'd1;
                if (cnt == 5'd31)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign quo = qneg ? -Z : Z;
    assign rem = rneg ? -R : R;

    // special cases override the datapath quotient/remainder
    always_comb begin
        res_nx = is_rem ? rem : quo;
        if (dz)
            res_nx = is_rem ? rem : 32'hFFFF_FFFF;
        else if (ovf)
            res_nx = is_rem ? 32'd0 : 32'h8000_0000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_rem <= 1'b0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
            result <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            valid <= (state == DONE);
            if (accept) begin
                is_rem <= op[1];
                qneg   <= sgn & (rs1[31] ^ rs2[31]);
                rneg   <= sgn & rs1[31];
                dz     <= dz_in;
                ovf    <= ovf_in;
            end
            if (state == DONE)
                result <= res_nx;
        end
    end

endmodule

// File: tb/tb_m_div_controller.sv
// Bench for m_div_controller: two instances (fast/slow special path)
// each paired with a behavioural restoring-divider datapath.
`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH   2
`define MUX_R_KEEP     2'd0
`define MUX_R_A        2'd1
`define MUX_R_A_NEG    2'd2
`define MUX_R_SUB_KEEP 2'd3
`endif
`ifndef MUX_D_LENGTH
`define MUX_D_LENGTH   2
`define MUX_D_KEEP     2'd0
`define MUX_D_B        2'd1
`define MUX_D_B_NEG    2'd2
`define MUX_D_SHR      2'd3
`endif
`ifndef MUX_Z_LENGTH
`define MUX_Z_LENGTH   2
`define MUX_Z_KEEP     2'd0
`define MUX_Z_ZERO     2'd1
`define MUX_Z_SHL_ADD  2'd2
`endif

module tb_m_div_controller;

    logic        clk;
    logic        resetn;
    logic [1:0]  start;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic [1:0]  busy, valid;
    logic [1:0][31:0] res;
    logic [1:0][`MUX_R_LENGTH-1:0] mr;
    logic [1:0][`MUX_D_LENGTH-1:0] md;
    logic [1:0][`MUX_Z_LENGTH-1:0] mz;
    logic [63:0] rq [2] = '{64'd0, 64'd0};
    logic [63:0] dq [2] = '{64'd0, 64'd0};
    logic [31:0] zq [2] = '{32'd0, 32'd0};

    logic [31:0] exp_q [$];
    int n_chk = 0;
    int n_fail = 0;

    m_div_controller #(.FAST_SPECIAL(1'b1)) u_fast (
        .clk(clk), .resetn(resetn), .start(start[0]), .op(op),
        .rs1(rs1), .rs2(rs2), .R(rq[0][31:0]), .Z(zq[0]),
        .mux_R(mr[0]), .mux_D(md[0]), .mux_Z(mz[0]),
        .busy(busy[0]), .valid(valid[0]), .result(res[0])
    );

    m_div_controller #(.FAST_SPECIAL(1'b0)) u_slow (
        .clk(clk), .resetn(resetn), .start(start[1]), .op(op),
        .rs1(rs1), .rs2(rs2), .R(rq[1][31:0]), .Z(zq[1]),
        .mux_R(mr[1]), .mux_D(md[1]), .mux_Z(mz[1]),
        .busy(busy[1]), .valid(valid[1]), .result(res[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // restoring divider: divisor starts at b<<31 and shifts right each step
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            case (mr[i])
                `MUX_R_A:        rq[i] <= {32'd0, rs1};
                `MUX_R_A_NEG:    rq[i] <= {32'd0, -rs1};
                `MUX_R_SUB_KEEP: if (rq[i] >= dq[i]) rq[i] <= rq[i] - dq[i];
                default: ;
            endcase
            case (md[i])
                `MUX_D_B:     dq[i] <= {1'b0, rs2, 31'd0};
                `MUX_D_B_NEG: dq[i] <= {1'b0, -rs2, 31'd0};
                `MUX_D_SHR:   dq[i] <= dq[i] >> 1;
                default: ;
            endcase
            case (mz[i])
                `MUX_Z_ZERO:    zq[i] <= 32'd0;
                `MUX_Z_SHL_ADD: zq[i] <= {zq[i][30:0], rq[i] >= dq[i]};
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input int i, input logic [1:0] o,
                                   input logic [31:0] a, input logic [31:0] b);
        logic sp;
        sp = (b == 32'd0) ||
             (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (i == 0 && sp) ? 1 : 33;
    endfunction

    task automatic issue(input int i, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        exp_q.push_back(ref_div(o, a, b));
    endtask

    task automatic wait_valid(input int i, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid[i] && lat < 100);
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 2'b11; op = 2'b00;
        rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_busy_valid: got %b want 0000", {busy, valid});
        end
        n_chk++;
        if (res !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 0", res);
        end
        n_chk++;
        if ({mr, md, mz} !== {`MUX_R_KEEP, `MUX_R_KEEP, `MUX_D_KEEP,
                              `MUX_D_KEEP, `MUX_Z_KEEP, `MUX_Z_KEEP}) begin
            n_fail++;
            $display("FAIL reset_selects: got %h want KEEP", {mr, md, mz});
        end
        start = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_first_op();
        int lat;
        logic [31:0] e;
        issue(0, 2'b01, 32'd100, 32'd7);
        n_chk++;
        if ({busy[0], mr[0], md[0], mz[0]} !==
            {1'b1, `MUX_R_SUB_KEEP, `MUX_D_SHR, `MUX_Z_SHL_ADD}) begin
            n_fail++;
            $display("FAIL iter_selects: got %h want %h",
                     {busy[0], mr[0], md[0], mz[0]},
                     {1'b1, `MUX_R_SUB_KEEP, `MUX_D_SHR, `MUX_Z_SHL_ADD});
        end
        wait_valid(0, lat);
        n_chk++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL divu_latency: got %0d want 33", lat);
        end
        e = exp_q.pop_front();
        n_chk++;
        if (res[0] !== e) begin
            n_fail++;
            $display("FAIL divu_100_7: got %h want %h", res[0], e);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({valid[0], busy[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL valid_one_cycle: got %b want 00", {valid[0], busy[0]});
        end
    endtask

    task automatic test_vectors();
        logic [1:0]  o [12] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10,
                                2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [31:0] a [12] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                32'd5, 32'hFFFF_FFFB, 32'd5, 32'd9,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000};
        logic [31:0] b [12] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF};
        int lat, le;
        logic [31:0] e;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 12; k++) begin
                issue(j, o[k], a[k], b[k]);
                le = ref_lat(j, o[k], a[k], b[k]);
                wait_valid(j, lat);
                n_chk++;
                if (lat !== le) begin
                    n_fail++;
                    $display("FAIL vec%0d_inst%0d_latency: got %0d want %0d",
                             k, j, lat, le);
                end
                e = exp_q.pop_front();
                n_chk++;
                if (res[j] !== e) begin
                    n_fail++;
                    $display("FAIL vec%0d_inst%0d_result: got %h want %h",
                             k, j, res[j], e);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, e;
        int lat, le;
        for (int k = 0; k < 16; k++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            issue(k % 2, o, a, b);
            le = ref_lat(k % 2, o, a, b);
            wait_valid(k % 2, lat);
            e = exp_q.pop_front();
            n_chk++;
            if (lat !== le || res[k % 2] !== e) begin
                n_fail++;
                $display("FAIL rand%0d op%0d %h/%h: got %h lat %0d want %h lat %0d",
                         k, o, a, b, res[k % 2], lat, e, le);
            end
        end
    endtask

    task automatic test_ignore_and_reset();
        int lat;
        logic seen;
        logic [31:0] e;
        issue(0, 2'b01, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start[0] = 1'b1; op = 2'b00; rs1 = 32'd50; rs2 = 32'd0;
        @(negedge clk);
        start[0] = 1'b0;
        wait_valid(0, lat);
        e = exp_q.pop_front();
        n_chk++;
        if (res[0] !== e) begin
            n_fail++;
            $display("FAIL ignore_result: got %h want %h", res[0], e);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | valid[0] | busy[0];
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_second_op: got %b want 0", seen);
        end
        issue(0, 2'b01, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        n_chk++;
        if ({busy[0], valid[0], res[0]} !== 34'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy %b valid %b result %h want 0 0 0",
                     busy[0], valid[0], res[0]);
        end
        @(negedge clk);
        resetn = 1'b1;
        issue(0, 2'b01, 32'd9, 32'd3);
        wait_valid(0, lat);
        e = exp_q.pop_front();
        n_chk++;
        if (lat !== 33 || res[0] !== e) begin
            n_fail++;
            $display("FAIL after_reset_divu: got %h lat %0d want %h lat 33",
                     res[0], lat, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o [3] = '{2'b01, 2'b10, 2'b00};
        logic [31:0] a [3] = '{32'd100, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] b [3] = '{32'd7, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] prev, e;
        int lat;
        prev = res[0];
        @(negedge clk);
        op = o[0]; rs1 = a[0]; rs2 = b[0]; start[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(ref_div(o[k], a[k], b[k]));
            if (k < 2) begin
                op = o[k + 1]; rs1 = a[k + 1]; rs2 = b[k + 1];
            end else begin
                start[0] = 1'b0;
            end
            n_chk++;
            if ({busy[0], valid[0], res[0]} !== {2'b10, prev}) begin
                n_fail++;
                $display("FAIL b2b%0d_accept: got busy %b valid %b result %h want 1 0 %h",
                         k, busy[0], valid[0], res[0], prev);
            end
            wait_valid(0, lat);
            e = exp_q.pop_front();
            n_chk++;
            if (lat !== 33 || res[0] !== e) begin
                n_fail++;
                $display("FAIL b2b%0d_result: got %h lat %0d want %h lat 33",
                         k, res[0], lat, e);
            end
            prev = e;
        end
        @(posedge clk); #1;
        n_chk++;
        if ({busy[0], valid[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end_idle: got %b want 00", {busy[0], valid[0]});
        end
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_vectors();
        test_random();
        test_ignore_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
